// File: rtl/synth_pkg.sv
// Shared encodings for the voice allocator: per-voice state, control FSM
// state, picker decision reason and the packed velocity field positions.
package synth_pkg;

   typedef enum logic [1:0] {
      V_FREE      = 2'd0,
      V_ACTIVE    = 2'd1,
      V_RELEASING = 2'd2
   } vstate_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_RETRIG = 2'd2
   } fsm_t;

   typedef enum logic [1:0] {
      R_SAME      = 2'd0,
      R_FREE      = 2'd1,
      R_RELEASING = 2'd2,
      R_STEAL     = 2'd3
   } reason_t;

   // velocity = {attack_level[31:16], decay_level[15:0]}
   localparam int ATTACK_MSB = 31;
   localparam int DECAY_MSB  = 15;

   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event valid/ready channel into the voice allocator.
interface voice_allocator_if #(
   parameter int NOTE_BITS = 7,
   parameter int VEL_BITS  = 32
);
   logic                 ev_valid;
   logic                 ev_ready;
   logic                 ev_on;
   logic [NOTE_BITS-1:0] ev_note;
   logic [VEL_BITS-1:0]  ev_vel;

   modport master (output ev_valid, output ev_on, output ev_note, output ev_vel,
                   input  ev_ready);
   modport slave  (input  ev_valid, input  ev_on, input  ev_note, input  ev_vel,
                   output ev_ready);
endinterface

// File: rtl/voice_picker.sv
// Combinational voice selection: same-note match, lowest free, lowest
// releasing, else the oldest active voice by modular stamp age.
module voice_picker
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 8,
   parameter int NOTE_BITS  = 7,
   parameter int STAMP_BITS = 8,
   parameter int IDX_W      = 3
) (
   input  vstate_t                vstate    [NUM_VOICES],
   input  logic [NOTE_BITS-1:0]   vnote     [NUM_VOICES],
   input  logic [STAMP_BITS-1:0]  stamp     [NUM_VOICES],
   input  logic [STAMP_BITS-1:0]  alloc_cnt,
   input  logic                   is_on,
   input  logic [NOTE_BITS-1:0]   note,
   output logic                   found,
   output logic [IDX_W-1:0]       idx,
   output reason_t                reason
);

   logic                  same_hit, free_hit, rel_hit, steal_hit;
   logic [IDX_W-1:0]      same_idx, free_idx, rel_idx, steal_idx;
   logic [STAMP_BITS-1:0] age, best_age;

   always_comb begin
      same_hit  = 1'b0;
      free_hit  = 1'b0;
      rel_hit   = 1'b0;
      steal_hit = 1'b0;
      same_idx  = '0;
      free_idx  = '0;
      rel_idx   = '0;
      steal_idx = '0;
      age       = '0;
      best_age  = '0;
      // Walk downwards so the last hit written is the lowest index; >= on age
      // makes ties also resolve to the lowest index.
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         age = alloc_cnt - stamp[i];
         if (vstate[i] == V_ACTIVE && vnote[i] == note) begin
            same_hit = 1'b1;
            same_idx = IDX_W'(i);
         end
         if (vstate[i] == V_FREE) begin
            free_hit = 1'b1;
            free_idx = IDX_W'(i);
         end
         if (vstate[i] == V_RELEASING) begin
            rel_hit = 1'b1;
            rel_idx = IDX_W'(i);
         end
         if (vstate[i] == V_ACTIVE && (!steal_hit || age >= best_age)) begin
            steal_hit = 1'b1;
            best_age  = age;
            steal_idx = IDX_W'(i);
         end
      end

      found  = same_hit;
      idx    = same_idx;
      reason = R_SAME;
      if (is_on && !same_hit) begin
         if (free_hit) begin
            found  = 1'b1;
            idx    = free_idx;
            reason = R_FREE;
         end else if (rel_hit) begin
            found  = 1'b1;
            idx    = rel_idx;
            reason = R_RELEASING;
         end else begin
            found  = steal_hit;
            idx    = steal_idx;
            reason = R_STEAL;
         end
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns note events to voices, gates their
// envelopes and recycles voices on the envelopes' available pulses.
module voice_allocator
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 8,
   parameter int NOTE_BITS  = 7,
   parameter int VEL_BITS   = 32,
   parameter int STAMP_BITS = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   voice_allocator_if.slave               ev,
   input  logic [NUM_VOICES-1:0]          voice_avail,
   output logic [NUM_VOICES-1:0]          voice_en,
   output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
   output logic [NUM_VOICES*VEL_BITS-1:0]  voice_vel,
   output logic                           ev_drop,
   output logic [4:0]                     active_cnt
);

   localparam int IDX_W = idx_bits(NUM_VOICES);

   fsm_t                  state;
   logic                  ev_on_p1;
   logic [NOTE_BITS-1:0]  ev_note_p1;
   logic [VEL_BITS-1:0]   ev_vel_p1;

   vstate_t               vstate   [NUM_VOICES];
   vstate_t               vstate_d [NUM_VOICES];
   logic [NOTE_BITS-1:0]  vnote    [NUM_VOICES];
   logic [VEL_BITS-1:0]   vvel     [NUM_VOICES];
   logic [STAMP_BITS-1:0] stamp    [NUM_VOICES];
   logic [STAMP_BITS-1:0] alloc_cnt;
   logic [IDX_W-1:0]      retrig_idx;
   logic [4:0]            cnt_d;

   logic                  pk_found;
   logic [IDX_W-1:0]      pk_idx;
   reason_t               pk_reason;

   assign ev.ev_ready = (state == S_IDLE);

   voice_picker #(
      .NUM_VOICES (NUM_VOICES),
      .NOTE_BITS  (NOTE_BITS),
      .STAMP_BITS (STAMP_BITS),
      .IDX_W      (IDX_W)
   ) u_picker (
      .vstate    (vstate),
      .vnote     (vnote),
      .stamp     (stamp),
      .alloc_cnt (alloc_cnt),
      .is_on     (ev_on_p1),
      .note      (ev_note_p1),
      .found     (pk_found),
      .idx       (pk_idx),
      .reason    (pk_reason)
   );

   // Next per-voice state: avail frees RELEASING voices, then the search
   // result overrides so an allocation beats a coinciding avail pulse.
   always_comb begin
      for (int i = 0; i < NUM_VOICES; i++) begin
         vstate_d[i] = vstate[i];
         if (voice_avail[i] && vstate[i] == V_RELEASING)
            vstate_d[i] = V_FREE;
      end
      if (state == S_SEARCH && pk_found)
         vstate_d[pk_idx] = ev_on_p1 ? V_ACTIVE : V_RELEASING;
      cnt_d = '0;
      for (int i = 0; i < NUM_VOICES; i++)
         if (vstate_d[i] == V_ACTIVE)
            cnt_d = cnt_d + 5'd1;
   end

   // Stage p1: event capture on acceptance.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && ev.ev_valid) begin
         ev_on_p1   <= ev.ev_on;
         ev_note_p1 <= ev.ev_note;
         ev_vel_p1  <= ev.ev_vel;
      end
   end

   // Stage p2: search result / retrigger re-gate.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         voice_en   <= '0;
         ev_drop    <= 1'b0;
         active_cnt <= '0;
         alloc_cnt  <= '0;
         retrig_idx <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            vstate[i] <= V_FREE;
            vnote[i]  <= '0;
            vvel[i]   <= '0;
            stamp[i]  <= '0;
         end
      end else begin
         ev_drop    <= 1'b0;
         active_cnt <= cnt_d;
         for (int i = 0; i < NUM_VOICES; i++)
            vstate[i] <= vstate_d[i];
         case (state)
            S_IDLE: begin
               if (ev.ev_valid)
                  state <= S_SEARCH;
            end
            S_SEARCH: begin
               state <= S_IDLE;
               if (ev_on_p1) begin
                  vnote[pk_idx] <= ev_note_p1;
                  vvel[pk_idx]  <= ev_vel_p1;
                  stamp[pk_idx] <= alloc_cnt;
                  alloc_cnt     <= alloc_cnt + STAMP_BITS'(1);
                  if (pk_reason == R_SAME || pk_reason == R_STEAL) begin
                     voice_en[pk_idx] <= 1'b0;
                     retrig_idx       <= pk_idx;
                     state            <= S_RETRIG;
                  end else begin
                     voice_en[pk_idx] <= 1'b1;
                  end
               end else if (pk_found) begin
                  voice_en[pk_idx] <= 1'b0;
               end else begin
                  ev_drop <= 1'b1;
               end
            end
            S_RETRIG: begin
               voice_en[retrig_idx] <= 1'b1;
               state                <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
      assign voice_note[g*NOTE_BITS +: NOTE_BITS] = vnote[g];
      assign voice_vel[g*VEL_BITS +: VEL_BITS]    = vvel[g];
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with four voices: vector table plus
// hand sequences for reset during retrigger and stamp wrap-around.
module tb_voice_allocator;
   import synth_pkg::*;

   localparam int NV = 4;
   localparam int NB = 7;
   localparam int VB = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [NV-1:0]     voice_avail;
   logic [NV-1:0]     voice_en;
   logic [NV*NB-1:0]  voice_note;
   logic [NV*VB-1:0]  voice_vel;
   logic              ev_drop;
   logic [4:0]        active_cnt;

   int errors = 0;
   int checks = 0;

   voice_allocator_if #(.NOTE_BITS(NB), .VEL_BITS(VB)) ev_if ();

   voice_allocator #(
      .NUM_VOICES (NV),
      .NOTE_BITS  (NB),
      .VEL_BITS   (VB),
      .STAMP_BITS (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ev          (ev_if),
      .voice_avail (voice_avail),
      .voice_en    (voice_en),
      .voice_note  (voice_note),
      .voice_vel   (voice_vel),
      .ev_drop     (ev_drop),
      .active_cnt  (active_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NV-1:0] pre_av;
      logic          on;
      logic [NB-1:0] note;
      logic [VB-1:0] vel;
      logic [NV-1:0] av;
      bit            retrig;
      int            v;
      logic [NV-1:0] en;
      logic [NB-1:0] xnote;
      logic [VB-1:0] xvel;
      logic          drop;
      logic [4:0]    cnt;
   } vec_t;

   vec_t tbl [14];

   function automatic logic [VB-1:0] mkvel(input logic [15:0] a, input logic [15:0] d);
      logic [VB-1:0] r;
      r = '0;
      r[ATTACK_MSB -: 16] = a;
      r[DECAY_MSB -: 16]  = d;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_avail(input logic [NV-1:0] m);
      @(negedge clk);
      voice_avail = m;
      @(negedge clk);
      voice_avail = '0;
   endtask

   // Returns at the negedge of the cycle where the event's result is visible.
   task automatic do_event(input logic on, input logic [NB-1:0] note, input logic [VB-1:0] vel,
                           input logic [NV-1:0] av, input bit retrig, input int rv);
      @(negedge clk);
      for (int k = 0; k < 20 && !ev_if.ev_ready; k++) @(negedge clk);
      chk("ready_wait", 64'(ev_if.ev_ready), 64'd1);
      ev_if.ev_valid = 1'b1;
      ev_if.ev_on    = on;
      ev_if.ev_note  = note;
      ev_if.ev_vel   = vel;
      @(posedge clk);
      @(negedge clk);
      ev_if.ev_valid = 1'b0;
      ev_if.ev_vel   = 32'hDEADBEEF;
      chk("ready_T1", 64'(ev_if.ev_ready), 64'd0);
      voice_avail = av;
      @(posedge clk);
      @(negedge clk);
      voice_avail = '0;
      if (retrig) begin
         chk("retrig_en_T2", 64'(voice_en[rv]), 64'd0);
         chk("retrig_ready_T2", 64'(ev_if.ev_ready), 64'd0);
         @(posedge clk);
         @(negedge clk);
      end
      chk("ready_done", 64'(ev_if.ev_ready), 64'd1);
   endtask

   function automatic logic [NB-1:0] note_of(input int v);
      return voice_note[v*NB +: NB];
   endfunction

   function automatic logic [VB-1:0] vel_of(input int v);
      return voice_vel[v*VB +: VB];
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_en"},    64'(voice_en),         64'd0);
      chk({tag, "_note"},  64'(voice_note),       64'd0);
      chk({tag, "_vel0"},  voice_vel[63:0],       64'd0);
      chk({tag, "_vel1"},  voice_vel[127:64],     64'd0);
      chk({tag, "_drop"},  64'(ev_drop),          64'd0);
      chk({tag, "_cnt"},   64'(active_cnt),       64'd0);
      chk({tag, "_ready"}, 64'(ev_if.ev_ready),   64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [VB-1:0] v0, v1, v2, v3, v4, v5, v6, v7, v8, junk;
      v0 = 32'hC0008000;
      v1 = mkvel(16'hA000, 16'h4000);
      v2 = mkvel(16'h9000, 16'h2000);
      v3 = mkvel(16'h8000, 16'h1000);
      v4 = mkvel(16'h7000, 16'h0800);
      v5 = mkvel(16'hFFFF, 16'h0001);
      v6 = 32'h12345678;
      v7 = 32'h0BAD0BAD;
      v8 = 32'h55550AAA;
      junk = 32'hDEADBEEF;

      //         pre_av  on    note   vel   av      rt  v  en       xnote  xvel drop cnt
      tbl[0]  = '{4'h0, 1'b1, 7'd60, v0,   4'b0000, 0, 0, 4'b0001, 7'd60, v0, 1'b0, 5'd1};
      tbl[1]  = '{4'h0, 1'b1, 7'd62, v1,   4'b0000, 0, 1, 4'b0011, 7'd62, v1, 1'b0, 5'd2};
      tbl[2]  = '{4'h0, 1'b1, 7'd64, v2,   4'b0000, 0, 2, 4'b0111, 7'd64, v2, 1'b0, 5'd3};
      tbl[3]  = '{4'h0, 1'b1, 7'd65, v3,   4'b0000, 0, 3, 4'b1111, 7'd65, v3, 1'b0, 5'd4};
      tbl[4]  = '{4'h0, 1'b1, 7'd67, v4,   4'b0000, 1, 0, 4'b1111, 7'd67, v4, 1'b0, 5'd4};
      tbl[5]  = '{4'h0, 1'b1, 7'd64, v5,   4'b0000, 1, 2, 4'b1111, 7'd64, v5, 1'b0, 5'd4};
      tbl[6]  = '{4'h0, 1'b0, 7'd62, junk, 4'b0000, 0, 1, 4'b1101, 7'd62, v1, 1'b0, 5'd3};
      tbl[7]  = '{4'h0, 1'b0, 7'd50, junk, 4'b0000, 0, 1, 4'b1101, 7'd62, v1, 1'b1, 5'd3};
      tbl[8]  = '{4'h0, 1'b1, 7'd70, v6,   4'b0010, 0, 1, 4'b1111, 7'd70, v6, 1'b0, 5'd4};
      tbl[9]  = '{4'h0, 1'b0, 7'd70, junk, 4'b0000, 0, 1, 4'b1101, 7'd70, v6, 1'b0, 5'd3};
      tbl[10] = '{4'h0, 1'b0, 7'd67, junk, 4'b0000, 0, 0, 4'b1100, 7'd67, v4, 1'b0, 5'd2};
      tbl[11] = '{4'h2, 1'b1, 7'd72, v7,   4'b0000, 0, 1, 4'b1110, 7'd72, v7, 1'b0, 5'd3};
      tbl[12] = '{4'h0, 1'b1, 7'd74, v8,   4'b0000, 0, 0, 4'b1111, 7'd74, v8, 1'b0, 5'd4};
      tbl[13] = '{4'h0, 1'b0, 7'd72, junk, 4'b0100, 0, 1, 4'b1101, 7'd72, v7, 1'b0, 5'd3};

      rst            = 1'b1;
      voice_avail    = '0;
      ev_if.ev_valid = 1'b0;
      ev_if.ev_on    = 1'b0;
      ev_if.ev_note  = '0;
      ev_if.ev_vel   = '0;

      do_reset();
      chk_all_zero("reset");

      for (int r = 0; r < 14; r++) begin
         if (tbl[r].pre_av != '0) pulse_avail(tbl[r].pre_av);
         do_event(tbl[r].on, tbl[r].note, tbl[r].vel, tbl[r].av, tbl[r].retrig, tbl[r].v);
         chk($sformatf("row%0d_en", r),   64'(voice_en),          64'(tbl[r].en));
         chk($sformatf("row%0d_note", r), 64'(note_of(tbl[r].v)), 64'(tbl[r].xnote));
         chk($sformatf("row%0d_vel", r),  64'(vel_of(tbl[r].v)),  64'(tbl[r].xvel));
         chk($sformatf("row%0d_drop", r), 64'(ev_drop),           64'(tbl[r].drop));
         chk($sformatf("row%0d_cnt", r),  64'(active_cnt),        64'(tbl[r].cnt));
         if (tbl[r].drop) begin
            @(negedge clk);
            chk($sformatf("row%0d_drop_once", r), 64'(ev_drop), 64'd0);
         end
      end

      // Release, free via avail, then the next note reuses voice 0.
      do_reset();
      do_event(1'b1, 7'd60, v0, 4'b0000, 0, 0);
      chk("seqA_on_en", 64'(voice_en), 64'b0001);
      do_event(1'b0, 7'd60, junk, 4'b0000, 0, 0);
      chk("seqA_off_en", 64'(voice_en), 64'b0000);
      chk("seqA_off_cnt", 64'(active_cnt), 64'd0);
      pulse_avail(4'b0001);
      do_event(1'b1, 7'd72, v7, 4'b0000, 0, 0);
      chk("seqA_reuse_en", 64'(voice_en), 64'b0001);
      chk("seqA_reuse_note", 64'(note_of(0)), 64'd72);

      // Reset asserted while in the retrigger cycle.
      do_reset();
      do_event(1'b1, 7'd60, v0, 4'b0000, 0, 0);
      do_event(1'b1, 7'd62, v1, 4'b0000, 0, 1);
      do_event(1'b1, 7'd64, v2, 4'b0000, 0, 2);
      do_event(1'b1, 7'd65, v3, 4'b0000, 0, 3);
      @(negedge clk);
      ev_if.ev_valid = 1'b1;
      ev_if.ev_on    = 1'b1;
      ev_if.ev_note  = 7'd67;
      ev_if.ev_vel   = v4;
      @(posedge clk);
      @(negedge clk);
      ev_if.ev_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("seqB_retrig_en", 64'(voice_en), 64'b1110);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_all_zero("seqB_rst");
      rst = 1'b0;
      do_event(1'b1, 7'd80, v5, 4'b0000, 0, 0);
      chk("seqB_after_en", 64'(voice_en), 64'b0001);
      chk("seqB_after_note", 64'(note_of(0)), 64'd80);

      // Stamp wrap: voice 0 keeps stamp 250 while the counter wraps past it.
      do_reset();
      for (int p = 0; p < 250; p++) begin
         do_event(1'b1, 7'd10, v1, 4'b0000, 0, 0);
         do_event(1'b0, 7'd10, junk, 4'b0000, 0, 0);
         pulse_avail(4'b0001);
      end
      do_event(1'b1, 7'd20, v2, 4'b0000, 0, 0);
      for (int p = 0; p < 50; p++) begin
         do_event(1'b1, 7'd30, v3, 4'b0000, 0, 1);
         do_event(1'b0, 7'd30, junk, 4'b0000, 0, 1);
         pulse_avail(4'b0010);
      end
      chk("seqC_v0_note", 64'(note_of(0)), 64'd20);
      do_event(1'b1, 7'd40, v4, 4'b0000, 0, 1);
      do_event(1'b1, 7'd41, v5, 4'b0000, 0, 2);
      do_event(1'b1, 7'd42, v6, 4'b0000, 0, 3);
      chk("seqC_full_cnt", 64'(active_cnt), 64'd4);
      do_event(1'b1, 7'd43, v8, 4'b0000, 1, 0);
      chk("seqC_steal_note0", 64'(note_of(0)), 64'd43);
      chk("seqC_steal_vel0", 64'(vel_of(0)), 64'(v8));
      chk("seqC_keep_note1", 64'(note_of(1)), 64'd40);
      chk("seqC_en", 64'(voice_en), 64'b1111);
      chk("seqC_cnt", 64'(active_cnt), 64'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice manager that drives the gate side of the per-voice envelope FSMs.
- Accepts note-on/note-off events over a valid/ready handshake and assigns each note to one of NUM_VOICES voices.
- Drives each voice's envelope enable and holds its note and packed velocity.
- Consumes each envelope's one-cycle `available` pulse to return a released voice to the free pool; steals the oldest voice when none is free.

Parameters:
- NUM_VOICES, 8, number of voices/envelope instances (2..16).
- NOTE_BITS, 7, note number width.
- VEL_BITS, 32, packed velocity width; {attack_level[31:16], decay_level[15:0]}.
- STAMP_BITS, 8, allocation-stamp width used for oldest-voice selection.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ev_valid  in  1  note event valid.
- ev_ready  out  1  allocator can accept an event.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_note  in  NOTE_BITS  note number.
- ev_vel  in  VEL_BITS  packed velocity; ignored for note-off.
- voice_avail  in  NUM_VOICES  per-voice `available` pulses from the envelopes.
- voice_en  out  NUM_VOICES  per-voice envelope enable (gate).
- voice_note  out  NUM_VOICES*NOTE_BITS  per-voice note, voice i at [i*NOTE_BITS +: NOTE_BITS].
- voice_vel  out  NUM_VOICES*VEL_BITS  per-voice velocity, same packing.
- ev_drop  out  1  one-cycle pulse: note-off matched no active voice.
- active_cnt  out  5  number of voices in ACTIVE.

Behaviour:
- Reset: voice_en=0, voice_note=0, voice_vel=0, ev_drop=0, every voice FREE, all stamps=0, alloc counter=0, FSM=S_IDLE. Reset mid-event abandons the event.
- Per-voice state:
  - FREE: not sounding.
  - ACTIVE: en=1.
  - RELEASING: en=0, waiting for the avail pulse.
- Control FSM:
  - S_IDLE: ev_ready=1 (combinational from state). On ev_valid & ev_ready, register the event and go to S_SEARCH.
  - S_SEARCH: ev_ready=0. Decide and register the result (rules below). Go to S_IDLE, or to S_RETRIG on a retrigger.
  - S_RETRIG: ev_ready=0. Set voice_en[v]=1 and go to S_IDLE.
- Latency, event accepted at edge T:
  - Free-voice assign or note-off: outputs change at T+2; ev_ready high at T+2.
  - Retrigger: voice_en[v]=0 at T+2 and 1 at T+3; ev_ready high at T+3.
- Note-on rules, in priority order:
  1. Same note already ACTIVE on voice v: retrigger v, so the envelope re-attacks with the new velocity.
  2. Else the lowest-index FREE voice: load note/vel, en=1, state ACTIVE.
  3. Else the lowest-index RELEASING voice: load note/vel, en=1 directly; the envelope goes RELEASE->ATTACK.
  4. Else steal the ACTIVE voice with the largest age (alloc_cnt - stamp, modulo 2^STAMP_BITS); ties go to the lowest index. Retrigger it.
- Retrigger: en=0 for exactly one cycle (S_SEARCH result), note/vel loaded in the same cycle, en=1 in S_RETRIG.
- Every note-on writes stamp[v]=alloc_cnt, then alloc_cnt increments (wraps).
- Note-off: the lowest-index ACTIVE voice with a matching note gets en=0 and goes to RELEASING; note/vel are held. No match: ev_drop pulses at T+2 and nothing else changes.
- voice_avail[i]:
  - On a RELEASING voice: voice goes FREE next cycle.
  - On a FREE or ACTIVE voice: ignored.
  - Coinciding with an S_SEARCH write to the same voice: the allocation wins and avail is ignored.
- active_cnt is registered and reflects per-voice state after each update.
- Velocity packing is passed through unchanged; no arithmetic is applied to it.

Decomposition:
- Shared package synth_pkg: voice-state encodings (V_FREE, V_ACTIVE, V_RELEASING), FSM state encodings, and the velocity field offsets (ATTACK_MSB=31, DECAY_MSB=15).
- Sub-module voice_picker: combinational priority/age selection over the per-voice state and stamp vectors. Outputs a found flag, the voice index, and the reason (same-note, free, releasing, steal).

Test Plan:
- NUM_VOICES=4. Reset, then note-on 60 vel 0xC000_8000 -> voice_en=0001 at T+2, voice 0 note=60, vel=0xC0008000, ev_ready low only at T+1.
- Note-on 60, 62, 64, 65, then 67 with all four ACTIVE -> voice 0 (oldest) en goes 1->0->1 over T+2/T+3, voice 0 note=67, active_cnt=4.
- Note-on 60, then note-off 60 -> voice_en[0]=0 at T+2. Pulse voice_avail[0] -> voice 0 FREE; next note-on 72 lands on voice 0.
- Note-off 50 with no match -> ev_drop single pulse at T+2, voice_en unchanged.
- Voice 1 RELEASING with no FREE voices; note-on 70 in the same cycle the avail[1] pulse arrives -> voice 1 en=1, note=70, state ACTIVE.
- Assert rst during S_RETRIG -> next cycle all outputs 0 and ev_ready=1; stamp wrap: 300 note-on/off pairs, then the steal picks the correct oldest voice.
